// File: rtl/seq_generator.sv
// Serial pattern generator: shifts out the low len bits of a captured pattern,
// MSB first, reps+1 times with GAP_CYC idle cycles between repetitions.
module seq_generator #(
    parameter int MAX_LEN = 8,
    parameter int GAP_CYC = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [MAX_LEN-1:0]             pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic [3:0]                     reps,
    output logic                           out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : {GAP_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic [3:0]         reps_r;
    logic [IDX_W-1:0]   idx_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               out_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic               len_ok_s;
    logic [IDX_W-1:0]   start_idx_s;
    logic [IDX_W-1:0]   restart_idx_s;
    logic [IDX_W-1:0]   idx_dec_s;

    // Start qualification and bit-index arithmetic; indices are truncated to the
    // pattern width so they can never point above len-1 for any legal len.
    always_comb begin
        len_ok_s      = 1'b0;
        start_idx_s   = {IDX_W{1'b0}};
        restart_idx_s = IDX_W'(len_r - LEN_W'(1));
        idx_dec_s     = idx_r - IDX_W'(1);
        if ((len != {LEN_W{1'b0}}) && (len <= MAX_LEN_V)) begin
            len_ok_s    = 1'b1;
            start_idx_s = IDX_W'(len - LEN_W'(1));
        end else begin
            len_ok_s    = 1'b0;
        end
    end

    // Main sequencer: state, captured job and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pat_r       <= {MAX_LEN{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            reps_r      <= 4'd0;
            idx_r       <= {IDX_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    out_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    if (start && len_ok_s) begin
                        pat_r       <= pattern;
                        len_r       <= len;
                        reps_r      <= reps;
                        idx_r       <= start_idx_s;
                        out_r       <= pattern[start_idx_s];
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_SHIFT;
                    end else if (start) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (idx_r != {IDX_W{1'b0}}) begin
                        idx_r <= idx_dec_s;
                        out_r <= pat_r[idx_dec_s];
                    end else if (reps_r != 4'd0) begin
                        if (GAP_CYC > 0) begin
                            gap_cnt_r   <= GAP_LAST;
                            out_r       <= 1'b0;
                            out_valid_r <= 1'b0;
                            state_r     <= ST_GAP;
                        end else begin
                            reps_r <= reps_r - 4'd1;
                            idx_r  <= restart_idx_s;
                            out_r  <= pat_r[restart_idx_s];
                        end
                    end else begin
                        out_r       <= 1'b0;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r != {GAP_W{1'b0}}) begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end else begin
                        reps_r      <= reps_r - 4'd1;
                        idx_r       <= restart_idx_s;
                        out_r       <= pat_r[restart_idx_s];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    out_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    out_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_seq_generator.sv
// Randomized bench for seq_generator: one instance with a 1-cycle gap and one
// with no gap share the stimulus and are compared against a cycle-index model.
module tb_seq_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;

    logic out_g1, vld_g1, busy_g1, done_g1, err_g1;
    logic out_g0, vld_g0, busy_g0, done_g0, err_g0;

    int total = 0;
    int bad   = 0;
    int hits  = 0;
    logic [3:0] hist;

    seq_generator #(.MAX_LEN(8), .GAP_CYC(1)) dut_g1 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
        .out(out_g1), .out_valid(vld_g1), .busy(busy_g1), .done(done_g1), .err(err_g1)
    );

    seq_generator #(.MAX_LEN(8), .GAP_CYC(0)) dut_g0 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
        .out(out_g0), .out_valid(vld_g0), .busy(busy_g0), .done(done_g0), .err(err_g0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {out_valid,out,busy,done} k cycles after the accepting edge.
    function automatic logic [3:0] exp_at(logic [7:0] p, int l, int r, int g, int k);
        int tot;
        int ph;
        tot = (r + 1) * l + r * g;
        if (k < tot) begin
            ph = k % (l + g);
            if (ph < l) return {1'b1, p[l - 1 - ph], 1'b1, 1'b0};
            return 4'b0010;
        end
        if (k == tot) return 4'b0001;
        return 4'b0000;
    endfunction

    // Called right after a negedge; checks every cycle through done and one idle.
    task automatic run_job(logic [7:0] p, int l, int r, int abort_at);
        logic [3:0] e1, e0, o1, o0;
        int last;
        rst = 1'b0; start = 1'b1; pattern = p; len = 4'(l); reps = 4'(r);
        hist = 4'b0000; hits = 0;
        last = (r + 1) * l + r + 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            e1 = exp_at(p, l, r, 1, k);
            e0 = exp_at(p, l, r, 0, k);
            o1 = {vld_g1, out_g1, busy_g1, done_g1};
            o0 = {vld_g0, out_g0, busy_g0, done_g0};
            total += 4;
            if (o1 !== e1) begin
                bad++;
                $display("FAIL job_gap1 p=%h l=%0d r=%0d k=%0d got vob d=%b want %b", p, l, r, k, o1, e1);
            end
            if (o0 !== e0) begin
                bad++;
                $display("FAIL job_gap0 p=%h l=%0d r=%0d k=%0d got vob d=%b want %b", p, l, r, k, o0, e0);
            end
            if (err_g1 !== 1'b0) begin
                bad++;
                $display("FAIL job_err_gap1 k=%0d got %b want 0", k, err_g1);
            end
            if (err_g0 !== 1'b0) begin
                bad++;
                $display("FAIL job_err_gap0 k=%0d got %b want 0", k, err_g0);
            end
            if (vld_g1) begin
                hist = {hist[2:0], out_g1};
                if (hist == 4'b1011) hits++;
            end
            if (k == abort_at) begin
                rst = 1'b1; start = 1'b1;
                @(negedge clk);
                total += 2;
                if ({out_g1, vld_g1, busy_g1, done_g1, err_g1} !== 5'b0) begin
                    bad++;
                    $display("FAIL abort_gap1 got %b want 00000", {out_g1, vld_g1, busy_g1, done_g1, err_g1});
                end
                if ({out_g0, vld_g0, busy_g0, done_g0, err_g0} !== 5'b0) begin
                    bad++;
                    $display("FAIL abort_gap0 got %b want 00000", {out_g0, vld_g0, busy_g0, done_g0, err_g0});
                end
                rst = 1'b0; start = 1'b0;
                return;
            end
            // Disturb inputs while both instances are still mid-job; must be ignored.
            start   = (e1 != 4'b0000 && e0 != 4'b0000) ? 1'($urandom_range(1)) : 1'b0;
            pattern = 8'($urandom);
            len     = 4'($urandom);
            reps    = 4'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pattern = 8'h0B; len = 4'd4; reps = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total += 2;
            if ({out_g1, vld_g1, busy_g1, done_g1, err_g1} !== 5'b0) begin
                bad++;
                $display("FAIL reset_gap1 got %b want 00000", {out_g1, vld_g1, busy_g1, done_g1, err_g1});
            end
            if ({out_g0, vld_g0, busy_g0, done_g0, err_g0} !== 5'b0) begin
                bad++;
                $display("FAIL reset_gap0 got %b want 00000", {out_g0, vld_g0, busy_g0, done_g0, err_g0});
            end
        end
        // start held across reset release is accepted on the first free edge
        run_job(8'h0B, 4, 0, -1);
    endtask

    task automatic test_vectors();
        run_job(8'h0B, 4, 2, -1);
        run_job(8'h05, 3, 1, -1);
        run_job(8'hA5, 1, 15, -1);
        run_job(8'h96, 8, 15, -1);
    endtask

    task automatic test_err();
        logic [3:0] bad_len[3];
        bad_len[0] = 4'd0;
        bad_len[1] = 4'd9;
        bad_len[2] = 4'(10 + $urandom_range(5));
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; len = bad_len[i]; pattern = 8'($urandom); reps = 4'($urandom);
            @(negedge clk);
            start = 1'b0;
            total += 2;
            if ({err_g1, busy_g1, vld_g1, done_g1} !== 4'b1000) begin
                bad++;
                $display("FAIL err_pulse_gap1 len=%0d got ebvd=%b want 1000", bad_len[i], {err_g1, busy_g1, vld_g1, done_g1});
            end
            if ({err_g0, busy_g0, vld_g0, done_g0} !== 4'b1000) begin
                bad++;
                $display("FAIL err_pulse_gap0 len=%0d got ebvd=%b want 1000", bad_len[i], {err_g0, busy_g0, vld_g0, done_g0});
            end
            @(negedge clk);
            total += 1;
            if ({err_g1, busy_g1, vld_g1, err_g0, busy_g0, vld_g0} !== 6'b0) begin
                bad++;
                $display("FAIL err_clear got %b want 000000", {err_g1, busy_g1, vld_g1, err_g0, busy_g0, vld_g0});
            end
        end
    endtask

    task automatic test_abort();
        run_job(8'h0B, 4, 2, 1);
        run_job(8'h5C, 6, 1, -1);
    endtask

    task automatic test_detector();
        int r;
        for (int i = 0; i < 3; i++) begin
            r = $urandom_range(4);
            run_job(8'h0B, 4, r, -1);
            total += 1;
            if (hits != r + 1) begin
                bad++;
                $display("FAIL detect_1011 reps=%0d got %0d want %0d", r, hits, r + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            run_job(8'($urandom), 1 + $urandom_range(7), (i % 5 == 0) ? 15 : $urandom_range(6), -1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = 8'h00; len = 4'd0; reps = 4'd0;
        test_reset();
        test_vectors();
        test_err();
        test_abort();
        test_detector();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
